// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Purpose  : I2S / left-justified audio transmitter with generated mclk/sclk.
//            Optional macro I2S_TX_UNDERRUN_CNT_EN adds underrun_cnt[15:0].
// Revision : 1.0  initial release
// ============================================================================
module i2s_tx #(
  parameter int MCLK_HALF = 4,
  parameter int SCLK_HALF = 16,
  parameter int DATA_W    = 24,
  parameter int SLOT_W    = 32,
  parameter int LJ_MODE   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s_data_l,
  input  logic [DATA_W-1:0] s_data_r,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              tx_mclk,
  output logic              tx_sclk,
  output logic              tx_lrclk,
  output logic              tx_sdout,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic [15:0]       underrun_cnt,
`endif
  output logic              underrun
);

  localparam int c_frame_bits = 2 * SLOT_W;
  localparam int c_bw         = $clog2(c_frame_bits);
  localparam int c_pad        = SLOT_W - DATA_W;
  localparam logic [15:0]     c_mclk_last = 16'(MCLK_HALF - 1);
  localparam logic [15:0]     c_sclk_last = 16'(SCLK_HALF - 1);
  localparam logic [c_bw-1:0] c_bit_last  = c_bw'(c_frame_bits - 1);
  localparam logic [c_bw-1:0] c_slot      = c_bw'(SLOT_W);

  if ((SCLK_HALF % MCLK_HALF) != 0) begin : g_bad_sclk_half
    $fatal(1, "i2s_tx: SCLK_HALF must be a multiple of MCLK_HALF");
  end
  if (SLOT_W < DATA_W) begin : g_bad_slot_w
    $fatal(1, "i2s_tx: SLOT_W must be >= DATA_W");
  end

  logic [15:0]             r_mcnt;
  logic [15:0]             r_scnt;
  logic                    r_mclk;
  logic                    r_sclk;
  logic                    r_lrclk;
  logic                    r_sdout;
  logic                    r_dly;
  logic                    r_full;
  logic                    r_underrun;
  logic [c_bw-1:0]         r_bitcnt;
  logic [DATA_W-1:0]       r_hold_l;
  logic [DATA_W-1:0]       r_hold_r;
  logic [c_frame_bits-1:0] r_shift;

  logic                    w_fall;
  logic                    w_frame_start;
  logic                    w_xfer;
  logic                    w_underrun;
  logic                    w_lj;
  logic [DATA_W-1:0]       w_src_l;
  logic [DATA_W-1:0]       w_src_r;
  logic [c_frame_bits-1:0] w_frame;

  // r_bitcnt is the index of the next bit to emit; index 0 marks frame start.
  assign w_fall        = (r_scnt == c_sclk_last) && r_sclk;
  assign w_frame_start = w_fall && (r_bitcnt == '0);
  assign w_xfer        = s_valid && !r_full;
  assign w_underrun    = w_frame_start && !r_full && !w_xfer;

  always_comb begin
    w_src_l = '0;
    w_src_r = '0;
    if (r_full) begin
      w_src_l = r_hold_l;
      w_src_r = r_hold_r;
    end else if (w_xfer) begin
      w_src_l = s_data_l;
      w_src_r = s_data_r;
    end
  end

  assign w_frame = {(SLOT_W'(w_src_l) << c_pad), (SLOT_W'(w_src_r) << c_pad)};
  assign w_lj    = w_frame_start ? w_frame[c_frame_bits-1] : r_shift[c_frame_bits-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcnt <= '0;
      r_scnt <= '0;
      r_mclk <= 1'b0;
      r_sclk <= 1'b1;
    end else begin
      if (r_mcnt == c_mclk_last) begin
        r_mcnt <= '0;
        r_mclk <= ~r_mclk;
      end else begin
        r_mcnt <= r_mcnt + 16'd1;
      end
      if (r_scnt == c_sclk_last) begin
        r_scnt <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_scnt <= r_scnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bitcnt   <= '0;
      r_lrclk    <= 1'b1;
      r_sdout    <= 1'b0;
      r_dly      <= 1'b0;
      r_shift    <= '0;
      r_full     <= 1'b0;
      r_hold_l   <= '0;
      r_hold_r   <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_fall) begin
        r_bitcnt <= (r_bitcnt == c_bit_last) ? '0 : r_bitcnt + c_bw'(1);
        r_lrclk  <= (r_bitcnt >= c_slot);
        r_shift  <= w_frame_start ? {w_frame[c_frame_bits-2:0], 1'b0}
                                  : {r_shift[c_frame_bits-2:0], 1'b0};
        // I2S emits the previous left-justified bit, giving the one-bit delay.
        r_sdout  <= (LJ_MODE != 0) ? w_lj : r_dly;
        r_dly    <= w_lj;
      end
      if (w_frame_start) begin
        r_full <= 1'b0;
      end else if (w_xfer) begin
        r_full   <= 1'b1;
        r_hold_l <= s_data_l;
        r_hold_r <= s_data_r;
      end
      r_underrun <= w_underrun;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_ucnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ucnt <= '0;
    end else if (w_underrun && (r_ucnt != 16'hFFFF)) begin
      r_ucnt <= r_ucnt + 16'd1;
    end
  end
  assign underrun_cnt = r_ucnt;
`endif

  assign s_ready  = ~r_full;
  assign tx_mclk  = r_mclk;
  assign tx_sclk  = r_sclk;
  assign tx_lrclk = r_lrclk;
  assign tx_sdout = r_sdout;
  assign underrun = r_underrun;

endmodule
`default_nettype wire
